// File: rtl/arrhythmia_stream_driver_if.sv
// rtl/arrhythmia_stream_driver_if.sv - stream, accelerator and status signals of the arrhythmia stream driver
interface arrhythmia_stream_driver_if #(
    parameter int BITSIZE = 16,
    parameter int N_IN    = 10,
    parameter int N_OUT   = 2
);
    logic                     s_valid;
    logic [BITSIZE-1:0]       s_data;
    logic                     s_ready;
    logic [BITSIZE*N_IN-1:0]  acc_x;
    logic                     acc_start;
    logic                     acc_done;
    logic [BITSIZE*N_OUT-1:0] acc_y;
    logic                     m_valid;
    logic [BITSIZE-1:0]       m_data;
    logic                     m_last;
    logic                     m_ready;
    logic                     busy;
    logic                     timeout_err;

    modport master (
        output s_valid, s_data, acc_done, acc_y, m_ready,
        input  s_ready, acc_x, acc_start, m_valid, m_data, m_last, busy, timeout_err
    );

    modport slave (
        input  s_valid, s_data, acc_done, acc_y, m_ready,
        output s_ready, acc_x, acc_start, m_valid, m_data, m_last, busy, timeout_err
    );
endinterface

// File: rtl/arrhythmia_stream_driver.sv
// rtl/arrhythmia_stream_driver.sv - gathers feature words, runs the accelerator, streams its results
module arrhythmia_stream_driver #(
    parameter int BITSIZE      = 16,
    parameter int N_IN         = 10,
    parameter int N_OUT        = 2,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic                        clk,
    input  logic                        reset_n,
    arrhythmia_stream_driver_if.slave   bus
);
    localparam int WCW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int OCW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int SCW = $clog2(START_CYCLES + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_LOAD, ST_START, ST_WAIT, ST_SEND} state_t;

    state_t                   state_q, state_d;
    logic [WCW-1:0]           word_cnt_q, word_cnt_d;
    logic [OCW-1:0]           out_idx_q, out_idx_d;
    logic [SCW-1:0]           start_cnt_q, start_cnt_d;
    logic [TCW-1:0]           wait_cnt_q, wait_cnt_d;
    logic [BITSIZE*N_IN-1:0]  acc_x_q, acc_x_d;
    logic [BITSIZE*N_OUT-1:0] ybuf_q, ybuf_d;
    logic                     done_q, done_d;
    logic                     timeout_err_q, timeout_err_d;

    logic               accept;
    logic               last_word;
    logic               last_out;
    logic               done_rise;
    logic               timeout_hit;
    logic [BITSIZE-1:0] word_in;

    assign accept      = (state_q == ST_LOAD) && bus.s_valid;
    assign last_word   = (word_cnt_q == WCW'(N_IN - 1));
    assign last_out    = (out_idx_q == OCW'(N_OUT - 1));
    // Edge detect so a done flag still high from a previous run cannot complete this one.
    assign done_rise   = (state_q == ST_WAIT) && bus.acc_done && !done_q;
    assign timeout_hit = (state_q == ST_WAIT) && !done_rise && (wait_cnt_q == TCW'(TIMEOUT - 1));
    assign word_in     = (bus.s_data == {1'b1, {(BITSIZE-1){1'b0}}}) ? '0 : bus.s_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_LOAD;
            word_cnt_q    <= '0;
            out_idx_q     <= '0;
            start_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            acc_x_q       <= '0;
            ybuf_q        <= '0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            out_idx_q     <= out_idx_d;
            start_cnt_q   <= start_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            acc_x_q       <= acc_x_d;
            ybuf_q        <= ybuf_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:  if (accept && last_word) state_d = ST_START;
            ST_START: if (start_cnt_q == SCW'(START_CYCLES - 1)) state_d = ST_WAIT;
            ST_WAIT: begin
                if (done_rise)        state_d = ST_SEND;
                else if (timeout_hit) state_d = ST_LOAD;
            end
            ST_SEND:  if (bus.m_ready && last_out) state_d = ST_LOAD;
            default:  state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        word_cnt_d    = word_cnt_q;
        out_idx_d     = out_idx_q;
        start_cnt_d   = '0;
        wait_cnt_d    = '0;
        acc_x_d       = acc_x_q;
        ybuf_d        = ybuf_q;
        done_d        = bus.acc_done;
        timeout_err_d = timeout_err_q | timeout_hit;

        if (accept) begin
            acc_x_d[BITSIZE*int'(word_cnt_q) +: BITSIZE] = word_in;
            word_cnt_d = last_word ? '0 : word_cnt_q + 1'b1;
        end
        if (state_q == ST_START) start_cnt_d = start_cnt_q + 1'b1;
        if (state_q == ST_WAIT)  wait_cnt_d  = wait_cnt_q + 1'b1;
        if (done_rise)           ybuf_d      = bus.acc_y;
        if ((state_q == ST_SEND) && bus.m_ready)
            out_idx_d = last_out ? '0 : out_idx_q + 1'b1;
    end

    always_comb begin
        bus.s_ready     = (state_q == ST_LOAD);
        bus.busy        = (state_q != ST_LOAD);
        bus.acc_start   = (state_q == ST_START);
        bus.acc_x       = acc_x_q;
        bus.m_valid     = (state_q == ST_SEND);
        bus.m_last      = (state_q == ST_SEND) && last_out;
        bus.m_data      = '0;
        bus.timeout_err = timeout_err_q;
        if (state_q == ST_SEND) bus.m_data = ybuf_q[BITSIZE*int'(out_idx_q) +: BITSIZE];
    end
endmodule

// File: doc/arrhythmia_stream_driver.md
ARRHYTHMIA_STREAM_DRIVER -- requirements
Module: arrhythmia_stream_driver

Interface
REQ-001 SHALL have parameter BITSIZE, default 16, word width (sign-magnitude: bit BITSIZE-1 sign, rest magnitude).
REQ-002 SHALL have parameter N_IN, default 10, input words per inference.
REQ-003 SHALL have parameter N_OUT, default 2, output words per inference.
REQ-004 SHALL have parameter START_CYCLES, default 2, cycles acc_start is held high.
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles before abort.
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port s_valid  input  1  upstream word valid.
REQ-009 SHALL have port s_data  input  BITSIZE  upstream feature word.
REQ-010 SHALL have port s_ready  output  1  driver accepts a word.
REQ-011 SHALL have port acc_x  output  BITSIZE*N_IN  feature vector to the accelerator x input.
REQ-012 SHALL have port acc_start  output  1  active-high start/reset pulse to the accelerator.
REQ-013 SHALL have port acc_done  input  1  accelerator done flag.
REQ-014 SHALL have port acc_y  input  BITSIZE*N_OUT  accelerator output vector.
REQ-015 SHALL have port m_valid  output  1  result word valid.
REQ-016 SHALL have port m_data  output  BITSIZE  result word.
REQ-017 SHALL have port m_last  output  1  high with last result word of an inference.
REQ-018 SHALL have port m_ready  input  1  downstream accepts a word.
REQ-019 SHALL have port busy  output  1  high in every state except LOAD.
REQ-020 SHALL have port timeout_err  output  1  sticky accelerator-timeout flag.

Function
REQ-021 SHALL implement FSM states LOAD, START, WAIT, SEND.
REQ-022 LOAD: s_ready=1; word accepted when s_valid&s_ready; k-th accepted word (k=0..N_IN-1) written to acc_x[BITSIZE*k +: BITSIZE].
REQ-023 SHALL convert negative zero (sign=1, magnitude=0) to all-zeros on capture; all other words stored unmodified.
REQ-024 On acceptance of word N_IN-1: next state START, word counter cleared.
REQ-025 START: acc_start=1 for exactly START_CYCLES consecutive cycles, then WAIT; acc_start=0 in all other states.
REQ-026 WAIT: cycle counter increments from 0 each cycle; acc_done registered each cycle; completion = rising edge (registered 0, current 1).
REQ-027 On completion: acc_y latched into output buffer, next state SEND; m_valid high the following cycle.
REQ-028 If counter reaches TIMEOUT with no completion: timeout_err set, no output emitted, next state LOAD.
REQ-029 SEND: m_valid=1; m_data = buffer word j, j=0 first (acc_y[BITSIZE-1:0]); j advances only on m_valid&m_ready; m_data stable while m_ready=0.
REQ-030 m_last=1 only with word N_OUT-1; its acceptance returns FSM to LOAD.
REQ-031 acc_x SHALL hold stable from START entry until the next LOAD word accepted.
REQ-032 s_ready=0 in START, WAIT, SEND; upstream words presented then are not consumed.
REQ-033 Latency: acceptance of last input word at cycle T -> acc_start high cycles T+1..T+START_CYCLES.

Reset
REQ-034 reset_n=0 SHALL asynchronously force state LOAD, counters 0, acc_x 0, buffer 0, acc_start 0, m_valid 0, m_data 0, m_last 0, timeout_err 0, registered acc_done 0; s_ready=1, busy=0.
REQ-035 Reset mid-operation SHALL discard partial inputs and pending results; first accepted word after release goes to element 0.

Verification
REQ-036 10 words 0x0001..0x000A, s_valid constant -> acc_x element k = k+1; acc_start high exactly 2 cycles starting cycle after 10th accept.
REQ-037 acc_done rises 20 cycles into WAIT, acc_y={0x3F00,0x0100} -> m_data 0x0100 then 0x3F00, m_last on second, then s_ready=1.
REQ-038 m_ready low 3 cycles during SEND -> m_valid held, m_data unchanged, no word skipped or duplicated.
REQ-039 acc_done held 0 -> timeout_err=1 after 255 WAIT cycles, m_valid never asserted, return to LOAD; stays 1 until reset_n=0.
REQ-040 s_data 0x8000 -> stored 0x0000; 0x8001 stored unmodified.
REQ-041 reset_n pulsed low after 4 words accepted -> all outputs at reset values; next 10 words fill elements 0..9.
